// File: rtl/pmem_pkg.sv
// Shared types and sizing for the cache-line burst master.
// Lines are 256 bits, moved to memory as four 64-bit beats.
package pmem_pkg;
   localparam int LINE_W      = 256;
   localparam int BEAT_W      = 64;
   localparam int NUM_BEATS   = 4;
   localparam int OFFSET_BITS = 5;
   localparam int CNT_W       = 2;

   typedef enum logic [1:0] {
      IDLE,
      RD_BURST,
      WR_BURST,
      DONE
   } state_t;
endpackage

// File: rtl/pmem_line_buffer.sv
// Beat-indexed line register: assembles read beats and
// serves write beats, slot k = bits [64k+63:64k].
module pmem_line_buffer
   import pmem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LINE_W-1:0] load_line,
   input  logic              beat_en,
   input  logic              capture,
   input  logic [BEAT_W-1:0] beat_in,
   output logic [BEAT_W-1:0] beat_out,
   output logic [LINE_W-1:0] assembled,
   output logic              last
);

   logic [LINE_W-1:0] line;
   logic [CNT_W-1:0]  cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         line <= '0;
         cnt  <= '0;
      end else if (load) begin
         line <= load_line;
         cnt  <= '0;
      end else if (beat_en) begin
         if (capture)
            line[BEAT_W*cnt +: BEAT_W] <= beat_in;
         cnt <= cnt + 1'b1;
      end
   end

   assign beat_out = line[BEAT_W*cnt +: BEAT_W];
   assign last     = (cnt == CNT_W'(NUM_BEATS - 1));
   // final beat lands in the top slot, so the full line is ready at that edge
   assign assembled = {beat_in, line[LINE_W-BEAT_W-1:0]};

endmodule

// File: rtl/pmem_burst_master.sv
// Arbitrates I/D cache line requests onto a single
// 4-beat physical memory burst port.
module pmem_burst_master
   import pmem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              icache_read,
   input  logic [31:0]       icache_address,
   output logic [LINE_W-1:0] icache_rdata,
   output logic              icache_resp,
   input  logic              dcache_read,
   input  logic              dcache_write,
   input  logic [31:0]       dcache_address,
   input  logic [LINE_W-1:0] dcache_wdata,
   output logic [LINE_W-1:0] dcache_rdata,
   output logic              dcache_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [31:0]       pmem_address,
   output logic [BEAT_W-1:0] pmem_wdata,
   input  logic [BEAT_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam logic [31:0] OFF_MASK = 32'((1 << OFFSET_BITS) - 1);

   state_t state, next;

   logic              grant;
   logic              grant_d;
   logic              sel_d;
   logic              in_burst;
   logic              beat_en;
   logic              last;
   logic [31:0]       req_addr;
   logic [BEAT_W-1:0] beat_out;
   logic [LINE_W-1:0] assembled;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next;
   end

   always_comb begin
      next    = state;
      grant   = 1'b0;
      grant_d = 1'b0;
      unique case (state)
         IDLE: begin
            if (dcache_write) begin
               grant   = 1'b1;
               grant_d = 1'b1;
               next    = WR_BURST;
            end else if (dcache_read) begin
               grant   = 1'b1;
               grant_d = 1'b1;
               next    = RD_BURST;
            end else if (icache_read) begin
               grant   = 1'b1;
               next    = RD_BURST;
            end
         end
         RD_BURST, WR_BURST: begin
            if (pmem_resp && last)
               next = DONE;
         end
         DONE:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   assign in_burst = (state == RD_BURST) || (state == WR_BURST);
   assign beat_en  = in_burst && pmem_resp;
   assign req_addr = grant_d ? dcache_address : icache_address;

   pmem_line_buffer u_line (
      .clk       (clk),
      .rst       (rst),
      .load      (grant),
      .load_line (dcache_wdata),
      .beat_en   (beat_en),
      .capture   (state == RD_BURST),
      .beat_in   (pmem_rdata),
      .beat_out  (beat_out),
      .assembled (assembled),
      .last      (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pmem_address <= '0;
         sel_d        <= 1'b0;
         icache_rdata <= '0;
         dcache_rdata <= '0;
      end else begin
         if (grant) begin
            pmem_address <= req_addr & ~OFF_MASK;
            sel_d        <= grant_d;
         end
         if (state == RD_BURST && pmem_resp && last) begin
            if (sel_d)
               dcache_rdata <= assembled;
            else
               icache_rdata <= assembled;
         end
      end
   end

   assign pmem_read   = (state == RD_BURST);
   assign pmem_write  = (state == WR_BURST);
   assign pmem_wdata  = pmem_write ? beat_out : '0;
   assign icache_resp = (state == DONE) && !sel_d;
   assign dcache_resp = (state == DONE) && sel_d;

endmodule

// File: tb/tb_pmem_burst_master.sv
// Bench for pmem_burst_master: memory responder plus a
// queue of expected bursts and a line-level memory model.
module tb_pmem_burst_master;

   logic         clk = 1'b0;
   logic         rst;
   logic         icache_read;
   logic [31:0]  icache_address;
   logic [255:0] icache_rdata;
   logic         icache_resp;
   logic         dcache_read;
   logic         dcache_write;
   logic [31:0]  dcache_address;
   logic [255:0] dcache_wdata;
   logic [255:0] dcache_rdata;
   logic         dcache_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [63:0]  pmem_wdata;
   logic [63:0]  pmem_rdata;
   logic         pmem_resp;

   pmem_burst_master dut (
      .clk            (clk),
      .rst            (rst),
      .icache_read    (icache_read),
      .icache_address (icache_address),
      .icache_rdata   (icache_rdata),
      .icache_resp    (icache_resp),
      .dcache_read    (dcache_read),
      .dcache_write   (dcache_write),
      .dcache_address (dcache_address),
      .dcache_wdata   (dcache_wdata),
      .dcache_rdata   (dcache_rdata),
      .dcache_resp    (dcache_resp),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]  addr;
      bit           wr;
      logic [255:0] line;
   } burst_t;

   burst_t       exp_q[$];
   logic [255:0] mem [logic [31:0]];
   logic [255:0] exp_i;
   logic [255:0] exp_d;
   int           n_cmp = 0;
   int           n_bad = 0;
   int           resp_gap = 0;
   int           beats = 0;
   bit           stray = 0;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] mem_get(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = rand_line();
      return mem[a];
   endfunction

   // memory responder: one resp every (resp_gap+1) cycles of a burst
   initial begin : responder
      int k;
      int w;
      bit in_b;
      burst_t cur;
      k = 0; w = 0; in_b = 0;
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(negedge clk);
         pmem_resp = 1'b0;
         pmem_rdata = {$urandom, $urandom};
         if (rst) begin
            k = 0; w = 0; in_b = 0;
         end else begin
            chk("rd_wr_excl", 256'(pmem_read && pmem_write), 256'd0);
            if (in_b)
               chk("burst_cont", 256'(pmem_read || pmem_write), 256'd1);
            if ((pmem_read || pmem_write) && !in_b) begin
               chk("burst_expected", 256'(exp_q.size() != 0), 256'd1);
               if (exp_q.size() != 0) begin
                  cur = exp_q.pop_front();
                  in_b = 1; k = 0; w = 0;
                  chk("burst_kind", 256'(pmem_write), 256'(cur.wr));
               end
            end
            if (in_b && (pmem_read || pmem_write)) begin
               chk("addr_stable", 256'(pmem_address), 256'(cur.addr));
               if (cur.wr)
                  chk("wdata_beat", 256'(pmem_wdata), 256'(cur.line[64*k +: 64]));
               if (w < resp_gap) begin
                  w++;
               end else begin
                  w = 0;
                  pmem_resp = 1'b1;
                  if (!cur.wr) pmem_rdata = cur.line[64*k +: 64];
                  k++;
                  beats = k;
                  if (k == 4) begin in_b = 0; k = 0; end
               end
            end else if (stray) begin
               pmem_resp = 1'b1;
            end
         end
      end
   end

   // kind: 0 = I read, 1 = D read, 2 = D write
   task automatic do_req(input int kind, input logic [31:0] addr,
                         input logic [255:0] wd, input int gap);
      burst_t b;
      int n;
      bit got;
      int lat;
      b.addr = addr & ~32'h1f;
      b.wr   = (kind == 2);
      b.line = (kind == 2) ? wd : mem_get(b.addr);
      exp_q.push_back(b);
      resp_gap = gap;
      lat = 1 + 4 * (gap + 1);
      icache_read    = (kind == 0);
      icache_address = addr;
      dcache_read    = (kind == 1);
      dcache_write   = (kind == 2);
      dcache_address = addr;
      dcache_wdata   = wd;
      n = 0; got = 0;
      while (n < lat + 10 && !got) begin
         @(negedge clk);
         n++;
         got = (kind == 0) ? icache_resp : dcache_resp;
         if (n == 2) begin
            icache_address = $urandom;
            dcache_address = $urandom;
            dcache_wdata   = rand_line();
         end
      end
      chk("resp_seen", 256'(got), 256'd1);
      chk("latency", 256'(n), 256'(lat));
      chk("other_resp", 256'((kind == 0) ? dcache_resp : icache_resp), 256'd0);
      chk("done_idle_bus", 256'({pmem_read, pmem_write}), 256'd0);
      if (kind == 0) exp_i = b.line;
      if (kind == 1) exp_d = b.line;
      if (kind == 2) mem[b.addr] = wd;
      chk("icache_rdata", icache_rdata, exp_i);
      chk("dcache_rdata", dcache_rdata, exp_d);
      icache_read = 0; dcache_read = 0; dcache_write = 0;
      @(negedge clk);
      chk("resp_one_cycle", 256'({icache_resp, dcache_resp}), 256'd0);
   endtask

   int n;
   bit got;
   logic [255:0] ex_line;
   logic [31:0]  a_i;
   logic [31:0]  a_d;

   initial begin
      rst = 1; stray = 0;
      icache_read = 0; icache_address = '0;
      dcache_read = 0; dcache_write = 0;
      dcache_address = '0; dcache_wdata = '0;
      exp_i = '0; exp_d = '0;
      repeat (3) @(negedge clk);
      chk("rst_pmem_rw", 256'({pmem_read, pmem_write}), 256'd0);
      chk("rst_resp", 256'({icache_resp, dcache_resp}), 256'd0);
      chk("rst_addr", 256'(pmem_address), 256'd0);
      chk("rst_wdata", 256'(pmem_wdata), 256'd0);
      chk("rst_irdata", icache_rdata, 256'd0);
      chk("rst_drdata", dcache_rdata, 256'd0);
      rst = 0;
      @(negedge clk);

      ex_line = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
      mem[32'h0000_0060] = ex_line;
      do_req(0, 32'h0000_0064, '0, 0);
      chk("example_iline", icache_rdata, ex_line);

      ex_line = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
      do_req(2, 32'h8000_0020, ex_line, 1);

      // simultaneous I and D reads: D wins, I follows
      a_d = 32'h0000_2040; a_i = 32'h0000_3080;
      exp_q.push_back('{a_d, 1'b0, mem_get(a_d)});
      exp_q.push_back('{a_i, 1'b0, mem_get(a_i)});
      resp_gap = 0;
      dcache_read = 1; dcache_address = a_d + 32'h5;
      icache_read = 1; icache_address = a_i + 32'h9;
      n = 0; got = 0;
      while (n < 40 && !got) begin
         @(negedge clk); n++; got = dcache_resp;
      end
      chk("sim_d_resp", 256'(got), 256'd1);
      chk("sim_i_waits", 256'(icache_resp), 256'd0);
      exp_d = mem[a_d];
      chk("sim_d_rdata", dcache_rdata, exp_d);
      dcache_read = 0;
      n = 0; got = 0;
      while (n < 6 && !got) begin
         @(negedge clk); n++; got = pmem_read;
      end
      chk("sim_i_start", 256'(n), 256'd2);
      n = 0; got = 0;
      while (n < 40 && !got) begin
         @(negedge clk); n++; got = icache_resp;
      end
      chk("sim_i_resp", 256'(got), 256'd1);
      exp_i = mem[a_i];
      chk("sim_i_rdata", icache_rdata, exp_i);
      icache_read = 0;
      @(negedge clk);

      do_req(1, 32'h0000_4444, '0, 10);

      // reset after beat 2 of an I read
      exp_q.push_back('{32'h0000_5000, 1'b0, mem_get(32'h0000_5000)});
      resp_gap = 2; beats = 0;
      icache_read = 1; icache_address = 32'h0000_5010;
      n = 0;
      while (n < 40 && beats < 2) begin
         @(negedge clk); n++;
      end
      chk("abort_reached_b2", 256'(beats), 256'd2);
      rst = 1; icache_read = 0;
      @(negedge clk);
      chk("abort_rd_low", 256'(pmem_read), 256'd0);
      chk("abort_no_resp", 256'(icache_resp), 256'd0);
      @(negedge clk);
      rst = 0;
      exp_i = '0; exp_d = '0;
      chk("abort_irdata", icache_rdata, exp_i);
      @(negedge clk);
      do_req(0, 32'h0000_5010, '0, 0);

      // stray acknowledges while idle
      stray = 1;
      repeat (3) begin
         @(negedge clk);
         chk("stray_idle", 256'({pmem_read, pmem_write, icache_resp, dcache_resp}), 256'd0);
      end
      stray = 0;
      do_req(0, 32'h0000_6000, '0, 0);

      for (int i = 0; i < 16; i++) begin
         do_req($urandom_range(0, 2),
                32'h1000_0000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31),
                rand_line(), $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
